// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word-wide data memory.
// Handles byte/half/word accesses, sub-word stores by read-modify-write, and address checks.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    input  logic        ReqRead,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqStoreData,
    output logic        Busy,
    output logic        Done,
    output logic        AddrErr,
    output logic [31:0] LoadData,
    output logic        MemRead,
    output logic [31:0] ReadAddress,
    input  logic [31:0] ReadData,
    output logic        MemWrite,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData
);

    localparam logic [1:0]  SIZE_BYTE  = 2'b00;
    localparam logic [1:0]  SIZE_HALF  = 2'b01;
    localparam logic [1:0]  SIZE_WORD  = 2'b10;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DATA  = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_off, op_off_nxt;
    logic [1:0]  op_size, op_size_nxt;
    logic        op_signed, op_signed_nxt;
    logic        op_write, op_write_nxt;
    logic [31:0] op_wdata, op_wdata_nxt;
    logic [31:0] mem_addr, mem_addr_nxt;

    logic        busy_nxt, done_nxt, addr_err_nxt, mem_read_nxt, mem_write_nxt;
    logic [31:0] load_data_nxt, write_data_nxt;

    logic        req_err_c;
    logic [1:0]  lane_idx_c;
    logic [4:0]  lane_shift_c;
    logic [31:0] lane_mask_c;
    logic [31:0] lane_val_c;
    logic [31:0] load_ext_c;
    logic [31:0] merged_c;

    // Address/size legality of the request currently presented
    always_comb begin
        req_err_c = (ReqSize == 2'b11)
                  | ((ReqSize == SIZE_HALF) & ReqAddr[0])
                  | ((ReqSize == SIZE_WORD) & (ReqAddr[1:0] != 2'b00))
                  | (ReqAddr >= ADDR_LIMIT);
    end

    // Lane position of the latched access within the memory word
    always_comb begin
        lane_idx_c = op_off;
        if (BIG_ENDIAN) begin
            lane_idx_c = (op_size == SIZE_HALF) ? (2'd2 - op_off) : (2'd3 - op_off);
        end
        lane_shift_c = {lane_idx_c, 3'b000};
        lane_mask_c  = (op_size == SIZE_HALF) ? (32'h0000_FFFF << lane_shift_c)
                                              : (32'h0000_00FF << lane_shift_c);
        lane_val_c   = ReadData >> lane_shift_c;
    end

    // Load extraction/extension and store lane merge
    always_comb begin
        case (op_size)
            SIZE_BYTE: load_ext_c = op_signed ? {{24{lane_val_c[7]}}, lane_val_c[7:0]}
                                              : {24'd0, lane_val_c[7:0]};
            SIZE_HALF: load_ext_c = op_signed ? {{16{lane_val_c[15]}}, lane_val_c[15:0]}
                                              : {16'd0, lane_val_c[15:0]};
            default:   load_ext_c = ReadData;
        endcase
        merged_c = (ReadData & ~lane_mask_c) | ((op_wdata << lane_shift_c) & lane_mask_c);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        op_off_nxt     = op_off;
        op_size_nxt    = op_size;
        op_signed_nxt  = op_signed;
        op_write_nxt   = op_write;
        op_wdata_nxt   = op_wdata;
        mem_addr_nxt   = mem_addr;
        done_nxt       = 1'b0;
        addr_err_nxt   = 1'b0;
        mem_read_nxt   = 1'b0;
        mem_write_nxt  = 1'b0;
        load_data_nxt  = LoadData;
        write_data_nxt = WriteData;

        case (state)
            IDLE: begin
                if (ReqValid && (ReqRead || ReqWrite)) begin
                    if (req_err_c) begin
                        done_nxt      = 1'b1;
                        addr_err_nxt  = 1'b1;
                        load_data_nxt = 32'd0;
                    end else begin
                        op_off_nxt    = ReqAddr[1:0];
                        op_size_nxt   = ReqSize;
                        op_signed_nxt = ReqSigned;
                        op_write_nxt  = ~ReqRead;
                        op_wdata_nxt  = ReqStoreData;
                        mem_addr_nxt  = {ReqAddr[31:2], 2'b00};
                        if (!ReqRead && (ReqSize == SIZE_WORD)) begin
                            state_nxt      = WR;
                            mem_write_nxt  = 1'b1;
                            write_data_nxt = ReqStoreData;
                        end else begin
                            state_nxt    = RD_ISSUE;
                            mem_read_nxt = 1'b1;
                        end
                    end
                end
            end
            RD_ISSUE: begin
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (op_write) begin
                    state_nxt      = WR;
                    mem_write_nxt  = 1'b1;
                    write_data_nxt = merged_c;
                end else begin
                    state_nxt     = IDLE;
                    done_nxt      = 1'b1;
                    load_data_nxt = load_ext_c;
                end
            end
            WR: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_off       <= 2'd0;
            op_size      <= 2'd0;
            op_signed    <= 1'b0;
            op_write     <= 1'b0;
            op_wdata     <= 32'd0;
            mem_addr     <= 32'd0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            AddrErr      <= 1'b0;
            LoadData     <= 32'd0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            ReadAddress  <= 32'd0;
            WriteAddress <= 32'd0;
            WriteData    <= 32'd0;
        end else begin
            state        <= state_nxt;
            op_off       <= op_off_nxt;
            op_size      <= op_size_nxt;
            op_signed    <= op_signed_nxt;
            op_write     <= op_write_nxt;
            op_wdata     <= op_wdata_nxt;
            mem_addr     <= mem_addr_nxt;
            Busy         <= busy_nxt;
            Done         <= done_nxt;
            AddrErr      <= addr_err_nxt;
            LoadData     <= load_data_nxt;
            MemRead      <= mem_read_nxt;
            MemWrite     <= mem_write_nxt;
            ReadAddress  <= mem_addr_nxt;
            WriteAddress <= mem_addr_nxt;
            WriteData    <= write_data_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a simple 32-word synchronous memory.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid, ReqRead, ReqWrite, ReqSigned;
    logic [1:0]  ReqSize;
    logic [31:0] ReqAddr, ReqStoreData;
    logic        Busy, Done, AddrErr, MemRead, MemWrite;
    logic [31:0] LoadData, ReadAddress, ReadData, WriteAddress, WriteData;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    int rd_delta, wr_delta, lat;
    logic [31:0] last_wa, last_wd;
    logic [31:0] mem [0:31];

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(32), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqRead(ReqRead), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
        .ReqStoreData(ReqStoreData),
        .Busy(Busy), .Done(Done), .AddrErr(AddrErr), .LoadData(LoadData),
        .MemRead(MemRead), .ReadAddress(ReadAddress), .ReadData(ReadData),
        .MemWrite(MemWrite), .WriteAddress(WriteAddress), .WriteData(WriteData)
    );

    // Attached data memory: registered read, write commits on the edge sampling MemWrite
    always @(posedge clk) begin
        if (MemWrite) mem[WriteAddress[6:2]] <= WriteData;
        if (MemRead)  ReadData <= mem[ReadAddress[6:2]];
    end

    // Memory port activity monitor
    always @(negedge clk) begin
        if (MemRead) rd_cnt++;
        if (MemWrite) begin
            wr_cnt++;
            last_wa = WriteAddress;
            last_wd = WriteData;
        end
        if (MemRead && MemWrite) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for Done; lat=0 means it never came
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] data, input bit perturb);
        int rd0, wr0;
        lat = 0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        ReqRead = rd; ReqWrite = wr; ReqSize = sz; ReqSigned = sgn;
        ReqAddr = addr; ReqStoreData = data; ReqValid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (perturb && i == 1) begin
                ReqAddr = 32'h10; ReqRead = 1'b0; ReqWrite = 1'b1;
                ReqSize = 2'b10; ReqStoreData = 32'hCAFE_F00D;
            end
            if (Done) begin
                lat = i;
                break;
            end
        end
        ReqValid = 1'b0; ReqRead = 1'b0; ReqWrite = 1'b0;
        rd_delta = rd_cnt - rd0;
        wr_delta = wr_cnt - wr0;
    endtask

    initial begin
        reset = 1'b1;
        ReqValid = 1'b0; ReqRead = 1'b0; ReqWrite = 1'b0; ReqSigned = 1'b0;
        ReqSize = 2'b00; ReqAddr = 32'd0; ReqStoreData = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_mem_rd", 32'(MemRead), 32'd0);
        check("rst_mem_wr", 32'(MemWrite), 32'd0);
        check("rst_load_data", LoadData, 32'd0);
        check("rst_raddr", ReadAddress, 32'd0);
        reset = 1'b0;

        // word store then word load
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        check("wst_lat", 32'(lat), 32'd2);
        check("wst_wr_cnt", 32'(wr_delta), 32'd1);
        check("wst_rd_cnt", 32'(rd_delta), 32'd0);
        check("wst_waddr", last_wa, 32'h10);
        check("wst_wdata", last_wd, 32'hDEAD_BEEF);
        check("wst_err", 32'(AddrErr), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(Done), 32'd0);

        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
        check("wld_lat", 32'(lat), 32'd3);
        check("wld_data", LoadData, 32'hDEAD_BEEF);
        check("wld_rd_cnt", 32'(rd_delta), 32'd1);
        check("wld_wr_cnt", 32'(wr_delta), 32'd0);

        // byte read-modify-write
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 1'b0);
        check("rmw_lat", 32'(lat), 32'd4);
        check("rmw_rd_cnt", 32'(rd_delta), 32'd1);
        check("rmw_wr_cnt", 32'(wr_delta), 32'd1);
        check("rmw_wdata", last_wd, 32'h11AA_3344);
        check("rmw_waddr", last_wa, 32'h10);
        check("rmw_ld_hold", LoadData, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
        check("rmw_readback", LoadData, 32'h11AA_3344);

        // halfword store into low half of word 0x8
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0102_0304, 1'b0);
        do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_BEEF, 1'b0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'd0, 1'b0);
        check("hst_readback", LoadData, 32'h0102_BEEF);

        // sub-word loads with sign/zero extension
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h80FF_7F01, 1'b0);
        do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'd0, 1'b0);
        check("ldb0_s", LoadData, 32'hFFFF_FF80);
        check("ldb_lat", 32'(lat), 32'd3);
        do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h3, 32'd0, 1'b0);
        check("ldb3_s", LoadData, 32'h0000_0001);
        do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h1, 32'd0, 1'b0);
        check("ldb1_u", LoadData, 32'h0000_00FF);
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h2, 32'd0, 1'b0);
        check("ldh2_u", LoadData, 32'h0000_7F01);
        do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'd0, 1'b0);
        check("ldh0_s", LoadData, 32'hFFFF_80FF);

        // error cases
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 1'b0);
        check("err_h_lat", 32'(lat), 32'd1);
        check("err_h_flag", 32'(AddrErr), 32'd1);
        check("err_h_ld", LoadData, 32'd0);
        check("err_h_busy", 32'(Busy), 32'd0);
        @(posedge clk); #1;
        check("err_pulse", 32'(AddrErr), 32'd0);
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h5555_5555, 1'b0);
        check("err_w_lat", 32'(lat), 32'd1);
        check("err_w_flag", 32'(AddrErr), 32'd1);
        check("err_w_mem", 32'(rd_delta + wr_delta), 32'd0);
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b0);
        check("err_sz_flag", 32'(AddrErr), 32'd1);
        check("err_sz_mem", 32'(rd_delta + wr_delta), 32'd0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 1'b0);
        check("err_oor_lat", 32'(lat), 32'd1);
        check("err_oor_flag", 32'(AddrErr), 32'd1);
        check("err_oor_mem", 32'(rd_delta + wr_delta), 32'd0);

        // read wins over write; neither set is ignored
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b0);
        check("prio_ld", LoadData, 32'h11AA_3344);
        check("prio_wr_cnt", 32'(wr_delta), 32'd0);
        @(negedge clk);
        ReqValid = 1'b1; ReqAddr = 32'h10; ReqSize = 2'b10;
        repeat (2) @(negedge clk);
        check("ignore_busy", 32'(Busy), 32'd0);
        check("ignore_done", 32'(Done), 32'd0);
        ReqValid = 1'b0;

        // request changed while busy has no effect
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 1'b1);
        check("busy_lat", 32'(lat), 32'd3);
        check("busy_ld", LoadData, 32'h80FF_7F01);
        check("busy_wr_cnt", 32'(wr_delta), 32'd0);

        // reset in RD_DATA of a halfword store
        begin
            int wr0;
            wr0 = wr_cnt;
            @(negedge clk);
            ReqRead = 1'b0; ReqWrite = 1'b1; ReqSize = 2'b01; ReqSigned = 1'b0;
            ReqAddr = 32'h10; ReqStoreData = 32'h0000_BEEF; ReqValid = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0;
            @(posedge clk); #1;
            check("rrst_done", 32'(Done), 32'd0);
            check("rrst_busy", 32'(Busy), 32'd0);
            check("rrst_memwr", 32'(MemWrite), 32'd0);
            check("rrst_ld", LoadData, 32'd0);
            check("rrst_waddr", WriteAddress, 32'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (2) @(negedge clk);
            check("rrst_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
        end
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
        check("rrst_mem", LoadData, 32'h11AA_3344);

        check("rw_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
